// File: rtl/train_request_agent_if.sv
// Bundles the agent's arrival, grant and status signals.
// The slave modport is the agent's own view; the master modport is the
// view of whatever drives arrivals and grants (arbiter or bench).
interface train_request_agent_if;
  logic [3:0] arrive;
  logic [2:0] grant;
  logic [3:0] train_request;
  logic       train_done;
  logic [3:0] cleared;
  logic       abort;
  logic       grant_err;
  logic       overflow;
  logic       busy;
  logic [1:0] active;

  modport master (
    output arrive, grant,
    input  train_request, train_done, cleared, abort, grant_err, overflow, busy, active
  );

  modport slave (
    input  arrive, grant,
    output train_request, train_done, cleared, abort, grant_err, overflow, busy, active
  );
endinterface

// File: rtl/train_request_agent.sv
// Section agent for four trains. It records each train's pending request,
// runs the granted train through the section for TRAVEL cycles, and reports
// completion, revoked grants, bad grants and duplicate arrivals as
// registered one-cycle pulses.
module train_request_agent #(
  parameter int unsigned TRAVEL = 4
) (
  input logic             clk,
  input logic             rst,
  train_request_agent_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Final count value; the grant edge loads 0, so DONE is entered on edge E0+TRAVEL.
  localparam logic [7:0] LAST = 8'(TRAVEL - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] act_q, act_d;
  logic [3:0] pend_q, pend_d;
  logic       done_q, done_d;
  logic [3:0] clr_q, clr_d;
  logic       abort_q, abort_d;
  logic       gerr_q, gerr_d;
  logic       ovf_q, ovf_d;

  logic       grant_legal;
  logic [1:0] grant_idx;
  logic [2:0] act_code;
  logic       grant_match;

  // Codes 001..100 name trains 0..3; 100 wraps to index 3 through the 2-bit subtract.
  assign grant_legal = (bus.grant != 3'd0) && (bus.grant <= 3'd4);
  assign grant_idx   = bus.grant[1:0] - 2'd1;
  assign act_code    = {1'b0, act_q} + 3'd1;
  assign grant_match = (bus.grant == act_code);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: start on a valid grant, leave RUN on revoke or on the last travel cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (grant_legal && pend_q[grant_idx]) state_d = RUN;
      RUN: begin
        if (!grant_match)        state_d = IDLE;
        else if (cnt_q == LAST)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and pulse outputs; the completing train's bit is cleared before arrivals
  // are merged so a same-edge arrival re-raises it instead of overflowing.
  always_comb begin
    cnt_d   = cnt_q;
    act_d   = act_q;
    done_d  = 1'b0;
    clr_d   = 4'b0000;
    abort_d = 1'b0;
    gerr_d  = 1'b0;
    ovf_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_legal) begin
          if (pend_q[grant_idx]) begin
            act_d = grant_idx;
            cnt_d = 8'd0;
          end else begin
            gerr_d = 1'b1;
          end
        end else if (bus.grant != 3'd0) begin
          gerr_d = 1'b1;
        end
      end
      RUN: begin
        if (!grant_match) begin
          abort_d = 1'b1;
          cnt_d   = 8'd0;
        end else if (cnt_q == LAST) begin
          done_d       = 1'b1;
          clr_d[act_q] = 1'b1;
          cnt_d        = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
    pend_d = pend_q & ~clr_d;
    for (int i = 0; i < 4; i++) begin
      if (bus.arrive[i]) begin
        if (!pend_q[i] || clr_d[i]) pend_d[i] = 1'b1;
        else                        ovf_d     = 1'b1;
      end
    end
  end

  // Datapath and pulse registers; reset discards any occupancy silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 8'd0;
      act_q   <= 2'd0;
      pend_q  <= 4'b0000;
      done_q  <= 1'b0;
      clr_q   <= 4'b0000;
      abort_q <= 1'b0;
      gerr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      abort_q <= abort_d;
      gerr_q  <= gerr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.train_request = pend_q;
  assign bus.train_done    = done_q;
  assign bus.cleared       = clr_q;
  assign bus.abort         = abort_q;
  assign bus.grant_err     = gerr_q;
  assign bus.overflow      = ovf_q;
  assign bus.busy          = (state_q == RUN) || (state_q == DONE);
  assign bus.active        = bus.busy ? act_q : 2'd0;

endmodule

// File: tb/tb_train_request_agent.sv
// Bench for train_request_agent: directed scenarios followed by random
// arrivals/grants, all checked cycle by cycle against a timestamp-based
// occupancy model.
module tb_train_request_agent;
  localparam int TRAVEL = 4;

  logic clk;
  logic rst;
  train_request_agent_if bus();

  train_request_agent #(.TRAVEL(TRAVEL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: pending set, current occupant and the edge its grant was accepted.
  logic [3:0] m_pend;
  int         m_owner;
  int         m_t0;
  bit         m_in_done;
  int         edge_no;
  logic       e_done, e_abort, e_gerr, e_ovf;
  logic [3:0] e_clr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    m_pend = 4'b0000; m_owner = -1; m_t0 = 0; m_in_done = 1'b0;
    e_done = 1'b0; e_clr = 4'b0000; e_abort = 1'b0; e_gerr = 1'b0; e_ovf = 1'b0;
  endtask

  // Applies the rules for one rising edge with the given inputs.
  task automatic model_edge(input logic [3:0] a, input logic [2:0] g);
    int fin;
    int k;
    logic [3:0] nxt;
    e_done = 1'b0; e_clr = 4'b0000; e_abort = 1'b0; e_gerr = 1'b0; e_ovf = 1'b0;
    fin = -1;
    k = int'(g) - 1;
    if (m_in_done) begin
      m_in_done = 1'b0;
      m_owner = -1;
    end else if (m_owner >= 0) begin
      if (int'(g) != m_owner + 1) begin
        e_abort = 1'b1;
        m_owner = -1;
      end else if (edge_no - m_t0 == TRAVEL) begin
        fin = m_owner;
        e_done = 1'b1;
        e_clr[fin] = 1'b1;
        m_in_done = 1'b1;
      end
    end else if (g >= 3'd5) begin
      e_gerr = 1'b1;
    end else if (g != 3'd0) begin
      if (m_pend[k]) begin
        m_owner = k;
        m_t0 = edge_no;
      end else begin
        e_gerr = 1'b1;
      end
    end
    nxt = m_pend;
    if (fin >= 0) nxt[fin] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (a[i]) begin
        if (m_pend[i] && i != fin) e_ovf = 1'b1;
        else                       nxt[i] = 1'b1;
      end
    end
    m_pend = nxt;
  endtask

  task automatic compare_all();
    check_val("request",   32'(bus.train_request), 32'(m_pend));
    check_val("done",      32'(bus.train_done),    32'(e_done));
    check_val("cleared",   32'(bus.cleared),       32'(e_clr));
    check_val("abort",     32'(bus.abort),         32'(e_abort));
    check_val("grant_err", 32'(bus.grant_err),     32'(e_gerr));
    check_val("overflow",  32'(bus.overflow),      32'(e_ovf));
    check_val("busy",      32'(bus.busy),          32'(m_owner >= 0));
    check_val("active",    32'(bus.active),        (m_owner >= 0) ? 32'(m_owner) : 32'd0);
  endtask

  task automatic step(input logic [3:0] a, input logic [2:0] g);
    bus.arrive = a;
    bus.grant  = g;
    model_edge(a, g);
    @(posedge clk);
    #1;
    compare_all();
    if (e_done)  $display("[TB] edge %0d: train %0d cleared", edge_no, m_owner);
    if (e_abort) $display("[TB] edge %0d: abort", edge_no);
    edge_no++;
    bus.arrive = 4'b0000;
  endtask

  // Asserts reset between edges and checks that everything clears at once.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] a;
    logic [2:0] g;
    int         pick;
    rst = 1'b1;
    bus.arrive = 4'b0000;
    bus.grant  = 3'b000;
    edge_no = 0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic completion with latency TRAVEL after the grant edge.
    step(4'b0001, 3'b000);
    for (int i = 0; i <= TRAVEL; i++) step(4'b0000, 3'b001);
    check_val("d_req_at_done", 32'(bus.train_request), 32'h0);
    check_val("d_done_at_e0p4", 32'(bus.train_done), 32'h1);
    step(4'b0000, 3'b000);
    check_val("d_done_one_cycle", 32'(bus.train_done), 32'h0);

    // Grant revoked mid-travel, then a normal re-grant.
    step(4'b0001, 3'b000);
    step(4'b0000, 3'b001);
    step(4'b0000, 3'b001);
    step(4'b0000, 3'b000);
    check_val("d_abort", 32'(bus.abort), 32'h1);
    check_val("d_abort_req", 32'(bus.train_request), 32'h1);
    for (int i = 0; i <= TRAVEL; i++) step(4'b0000, 3'b001);
    step(4'b0000, 3'b000);

    // Two simultaneous arrivals served back to back.
    step(4'b0110, 3'b000);
    for (int i = 0; i <= TRAVEL; i++) step(4'b0000, 3'b010);
    check_val("d_clr1", 32'(bus.cleared), 32'h2);
    step(4'b0000, 3'b000);
    for (int i = 0; i <= TRAVEL; i++) step(4'b0000, 3'b011);
    check_val("d_clr2", 32'(bus.cleared), 32'h4);
    step(4'b0000, 3'b000);
    check_val("d_req_empty", 32'(bus.train_request), 32'h0);

    // Illegal and non-pending grants, then a duplicate arrival.
    step(4'b0000, 3'b101);
    check_val("d_gerr_illegal", 32'(bus.grant_err), 32'h1);
    step(4'b0000, 3'b100);
    check_val("d_gerr_nopend", 32'(bus.grant_err), 32'h1);
    step(4'b0001, 3'b000);
    step(4'b0001, 3'b000);
    check_val("d_overflow", 32'(bus.overflow), 32'h1);

    // Re-arrival on the completion edge keeps the request alive.
    for (int i = 0; i < TRAVEL; i++) step(4'b0000, 3'b001);
    step(4'b0001, 3'b001);
    check_val("d_rearr_clr", 32'(bus.cleared), 32'h1);
    check_val("d_rearr_req", 32'(bus.train_request), 32'h1);
    check_val("d_rearr_ovf", 32'(bus.overflow), 32'h0);
    step(4'b0000, 3'b000);

    // Reset in the middle of a run, then immediate acceptance of a new arrival.
    step(4'b0000, 3'b001);
    step(4'b0000, 3'b001);
    async_reset();
    step(4'b1000, 3'b000);

    // Randomised traffic from an arbiter that mostly behaves.
    for (int n = 0; n < 600; n++) begin
      a = 4'b0000;
      for (int i = 0; i < 4; i++) if ($urandom_range(99) < 15) a[i] = 1'b1;
      pick = int'($urandom_range(99));
      if (m_owner >= 0 && !m_in_done) begin
        g = (pick < 85) ? 3'(m_owner + 1) : 3'($urandom_range(7));
      end else if (m_in_done) begin
        g = 3'($urandom_range(7));
      end else if (pick < 60 && m_pend != 4'b0000) begin
        int t;
        t = int'($urandom_range(3));
        while (!m_pend[t]) t = (t + 1) % 4;
        g = 3'(t + 1);
      end else if (pick < 75) begin
        g = 3'($urandom_range(7));
      end else begin
        g = 3'b000;
      end
      step(a, g);
      if (n == 300 && m_owner >= 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
